// File: rtl/aes_decrypt_core_if.sv
// aes_decrypt_core_if -- request/result bundle for the AES-128 decrypt core.
//
// Signals:
//   start       requester -> core  start a decryption (sampled only when idle)
//   ciphertext  requester -> core  [0:127] block, byte 0 = bits [0:7], column-major
//   key         requester -> core  [0:127] AES-128 cipher key, same byte order
//   busy        core -> requester  high whenever the core is not idle
//   done        core -> requester  one-cycle pulse when plaintext becomes valid
//   plaintext   core -> requester  [0:127] result, held until the next accepted start
//
// Modports: master (requester side), slave (core side).
interface aes_decrypt_core_if;
  logic         start;
  logic [0:127] ciphertext;
  logic [0:127] key;
  logic         busy;
  logic         done;
  logic [0:127] plaintext;

  modport master (
    output start, ciphertext, key,
    input  busy, done, plaintext
  );

  modport slave (
    input  start, ciphertext, key,
    output busy, done, plaintext
  );
endinterface

// File: rtl/aes_decrypt_core.sv
// aes_decrypt_core -- iterative AES-128 block decryption, one round per cycle.
//
// Flow: IDLE accepts a block and key, KEYEXP expands one round key per cycle
// into an 11-entry key file, ROUND applies the ten inverse rounds (r = 9..0),
// DONE hands the result to the plaintext register and raises done for one
// cycle, after which the core is idle again.
//
// Ports:
//   clk    input  rising-edge clock
//   reset  input  synchronous active-high reset
//   bus    aes_decrypt_core_if.slave  start/ciphertext/key in, busy/done/plaintext out
//
// Optional build macro: AES_DEC_KEY_CACHE_EN
//   When defined, the core remembers the last fully expanded key. A request
//   with the same key skips KEYEXP and goes straight to ROUND.
//
// Also contains the leaf lookup modules aes_sbox and aes_inv_sbox.

module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign y = TABLE[x];
endmodule

module aes_inv_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [0:255][7:0] TABLE = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };
  assign y = TABLE[x];
endmodule

module aes_decrypt_core (
  input  logic                     clk,
  input  logic                     reset,
  aes_decrypt_core_if.slave        bus
);
  typedef logic [0:15][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_t;

  state_t     state, state_next;
  logic       busy_w;
  blk_t       rk [0:10];
  blk_t       st;
  blk_t       pt;
  logic       done_q;
  logic [3:0] r;
  logic [3:0] kidx;
  logic       hit;
  blk_t       key_in, ct_in;

  assign key_in        = bus.key;
  assign ct_in         = bus.ciphertext;
  assign bus.busy      = busy_w;
  assign bus.done      = done_q;
  assign bus.plaintext = pt;

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiplier m is one of 9, b, d, e: all have bit 3 set, so x8 is always
  // included and the lower bits select x4, x2 and x.
  function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ (m[2] ? x4 : 8'h00) ^ (m[1] ? x2 : 8'h00) ^ (m[0] ? b : 8'h00);
  endfunction

  function automatic blk_t inv_mix_columns(input blk_t s);
    blk_t o;
    for (int c = 0; c < 4; c++) begin
      o[4*c]   = gmul(s[4*c], 4'he) ^ gmul(s[4*c+1], 4'hb) ^ gmul(s[4*c+2], 4'hd) ^ gmul(s[4*c+3], 4'h9);
      o[4*c+1] = gmul(s[4*c], 4'h9) ^ gmul(s[4*c+1], 4'he) ^ gmul(s[4*c+2], 4'hb) ^ gmul(s[4*c+3], 4'hd);
      o[4*c+2] = gmul(s[4*c], 4'hd) ^ gmul(s[4*c+1], 4'h9) ^ gmul(s[4*c+2], 4'he) ^ gmul(s[4*c+3], 4'hb);
      o[4*c+3] = gmul(s[4*c], 4'hb) ^ gmul(s[4*c+1], 4'hd) ^ gmul(s[4*c+2], 4'h9) ^ gmul(s[4*c+3], 4'he);
    end
    return o;
  endfunction

  // ---- key schedule: rk[kidx] -> rk[kidx+1] ----
  blk_t       kprev, knext;
  logic [7:0] ksub [0:3];
  logic [31:0] ktemp, w0, w1, w2, w3;

  assign kprev = rk[kidx];

  // RotWord is folded into the wiring: S-box i takes byte 12 + (i+1)%4.
  for (genvar i = 0; i < 4; i++) begin : g_ksub
    aes_sbox u_sbox (.x(kprev[12 + ((i + 1) % 4)]), .y(ksub[i]));
  end

  always_comb begin
    ktemp = {ksub[0] ^ rcon(kidx), ksub[1], ksub[2], ksub[3]};
    w0    = {kprev[0],  kprev[1],  kprev[2],  kprev[3]}  ^ ktemp;
    w1    = {kprev[4],  kprev[5],  kprev[6],  kprev[7]}  ^ w0;
    w2    = {kprev[8],  kprev[9],  kprev[10], kprev[11]} ^ w1;
    w3    = {kprev[12], kprev[13], kprev[14], kprev[15]} ^ w2;
    knext = {w0, w1, w2, w3};
  end

  // ---- inverse round: InvShiftRows + InvSubBytes + AddRoundKey (+ InvMixColumns) ----
  logic [7:0] isub [0:15];
  blk_t       rk_cur, ark, rnext;

  // InvShiftRows rotates row `row` right by `row`, so output (row, col)
  // comes from input column (col - row) mod 4; the S-box lookup commutes
  // with the byte move, so both are done by one instance per byte.
  for (genvar i = 0; i < 16; i++) begin : g_isub
    localparam int ROW = i % 4;
    localparam int COL = i / 4;
    localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
    aes_inv_sbox u_inv_sbox (.x(st[SRC]), .y(isub[i]));
  end

  always_comb begin
    rk_cur = rk[r];
    for (int i = 0; i < 16; i++) ark[i] = isub[i] ^ rk_cur[i];
    rnext = (r == 4'd0) ? ark : inv_mix_columns(ark);
  end

  // ---- optional expanded-key cache ----
`ifdef AES_DEC_KEY_CACHE_EN
  logic key_valid;
  blk_t cache_key;

  always_ff @(posedge clk) begin
    if (reset)
      key_valid <= 1'b0;
    else if (state == IDLE && bus.start && !hit)
      key_valid <= 1'b0;
    else if (state == KEYEXP && kidx == 4'd9)
      key_valid <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state == KEYEXP && kidx == 4'd9)
      cache_key <= rk[0];
  end

  assign hit = key_valid && (key_in == cache_key);
`else
  assign hit = 1'b0;
`endif

  // ---- control FSM ----
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy_w     = 1'b1;
    case (state)
      IDLE: begin
        busy_w = 1'b0;
        if (bus.start) state_next = hit ? ROUND : KEYEXP;
      end
      KEYEXP:  if (kidx == 4'd9) state_next = ROUND;
      ROUND:   if (r == 4'd0)    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- key file, counters and result register ----
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 11; i++) rk[i] <= '0;
      pt     <= '0;
      done_q <= 1'b0;
      r      <= '0;
      kidx   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            kidx <= '0;
            if (hit) r <= 4'd9;
            else     rk[0] <= key_in;
          end
        end
        KEYEXP: begin
          rk[kidx + 4'd1] <= knext;
          kidx            <= kidx + 4'd1;
          if (kidx == 4'd9) r <= 4'd9;
        end
        ROUND: begin
          if (r != 4'd0) r <= r - 4'd1;
        end
        DONE: begin
          pt     <= st;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---- cipher state register ----
  // Holds the ciphertext during KEYEXP; rk10 is folded in on the edge that
  // produces it, so ROUND starts on the very next cycle.
  always_ff @(posedge clk) begin
    case (state)
      IDLE:    if (bus.start) st <= hit ? (ct_in ^ rk[10]) : ct_in;
      KEYEXP:  if (kidx == 4'd9) st <= st ^ knext;
      ROUND:   st <= rnext;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_aes_decrypt_core.sv
// Directed bench for aes_decrypt_core using FIPS-197 vectors.
module tb_aes_decrypt_core;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  aes_decrypt_core_if bus ();

  aes_decrypt_core dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_Z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam int HIT_LAT = 11;
`else
  localparam int HIT_LAT = 21;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request, returns the number of rising edges after the
  // accepting edge at which done was first seen (-1 if never).
  task automatic run_block(input string tag, input logic [127:0] k,
                           input logic [127:0] c, output int lat);
    @(negedge clk);
    bus.key        = k;
    bus.ciphertext = c;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, 128'(bus.busy), 128'd1);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int extra;
    logic [127:0] held;
    checks   = 0;
    failures = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.key        = '0;
    bus.ciphertext = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 128'(bus.busy), 128'd0);
    chk("reset_done", 128'(bus.done), 128'd0);
    chk("reset_pt",   bus.plaintext,  128'd0);

    // start coincident with reset must be dropped
    @(negedge clk);
    bus.key        = K_C1;
    bus.ciphertext = CT_C1;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("start_in_reset_busy", 128'(bus.busy), 128'd0);

    // FIPS-197 C.1
    run_block("c1", K_C1, CT_C1, lat);
    chk("c1_latency", 128'(lat), 128'd21);
    chk("c1_pt", bus.plaintext, PT_C1);
    @(posedge clk);
    #1;
    chk("c1_done_width", 128'(bus.done), 128'd0);
    chk("c1_pt_hold", bus.plaintext, PT_C1);
    chk("c1_idle", 128'(bus.busy), 128'd0);

    // same key again: cache hit when the cache is built in
    run_block("c1b", K_C1, CT_C1, lat);
    chk("c1_repeat_latency", 128'(lat), 128'(HIT_LAT));
    chk("c1_repeat_pt", bus.plaintext, PT_C1);
    @(posedge clk);
    #1;

    // FIPS-197 appendix B, different key
    run_block("b", K_B, CT_B, lat);
    chk("b_latency", 128'(lat), 128'd21);
    chk("b_pt", bus.plaintext, PT_B);
    @(posedge clk);
    #1;

    // reset in the fifth ROUND cycle
    @(negedge clk);
    bus.key        = K_C1;
    bus.ciphertext = CT_C1;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("pre_reset_busy", 128'(bus.busy), 128'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midround_reset_busy", 128'(bus.busy), 128'd0);
    chk("midround_reset_done", 128'(bus.done), 128'd0);
    chk("midround_reset_pt",   bus.plaintext,  128'd0);
    @(negedge clk);
    reset = 1'b0;

    run_block("c1r", K_C1, CT_C1, lat);
    chk("after_reset_latency", 128'(lat), 128'd21);
    chk("after_reset_pt", bus.plaintext, PT_C1);
    @(posedge clk);
    #1;

    // all-zero key with start pulses and input changes while busy
    @(negedge clk);
    bus.key        = '0;
    bus.ciphertext = CT_Z;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = n;
        break;
      end
      if (n == 3 || n == 15) begin
        bus.start      = 1'b1;
        bus.key        = K_B ^ 128'(n);
        bus.ciphertext = ~CT_Z;
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("zero_latency", 128'(lat), 128'd21);
    chk("zero_pt", bus.plaintext, 128'd0);
    held  = bus.plaintext;
    extra = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (bus.done) extra++;
    end
    chk("zero_no_second_done", 128'(extra), 128'd0);
    chk("zero_pt_stable", bus.plaintext, held);
    chk("zero_final_idle", 128'(bus.busy), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
